// File: rtl/signal_meas_sched.sv
// Round-robin period/high-time measurement of CH_NUM asynchronous inputs on one
// shared counter datapath; results are converted to ns and sent over valid/ready.
`timescale 1ns/1ps
module signal_meas_sched #(
    parameter int unsigned CH_NUM        = 4,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned CLK_PERIOD_NS = 20,
    parameter int unsigned TIMEOUT_CYC   = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode_cont,
    input  logic [CH_NUM-1:0] ch_en,
    input  logic [CH_NUM-1:0] signal,
    output logic              busy,
    output logic              sweep_done,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [2:0]        res_ch,
    output logic [CNT_W-1:0]  res_period_ns,
    output logic [CNT_W-1:0]  res_high_ns,
    output logic              res_timeout
);
    localparam int unsigned PTR_W = $clog2(CH_NUM + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] NS_MUL  = CNT_W'(CLK_PERIOD_NS);

    typedef enum logic [2:0] {IDLE, SEL, ARM, HIGH, LOW, REPORT} state_t;

    state_t            state_q;
    logic [CH_NUM-1:0] s1_q, s2_q, s3_q;
    logic [CH_NUM-1:0] en_q;
    logic [PTR_W-1:0]  ptr_q;
    logic [2:0]        ch_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [CNT_W-1:0]  cyc_q;
    logic [CNT_W-1:0]  high_cyc_q;

    logic [7:0] rise_w, fall_w;
    logic       rise_sel, fall_sel, measuring, timeout_w;
    logic       sel_found_w;
    logic [2:0] sel_idx_w;

    // Two-flop synchronizer plus delay flop on every channel, always running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= signal;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_w    = 8'(s2_q & ~s3_q);
    assign fall_w    = 8'(~s2_q & s3_q);
    assign rise_sel  = rise_w[ch_q];
    assign fall_sel  = fall_w[ch_q];
    assign measuring = (state_q == ARM) || (state_q == HIGH) || (state_q == LOW);
    assign timeout_w = (to_cnt_q == TO_LAST);

    // Lowest enabled channel at or above the sweep pointer
    always_comb begin
        sel_found_w = 1'b0;
        sel_idx_w   = 3'd0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (en_q[i] && (PTR_W'(i) >= ptr_q)) begin
                sel_found_w = 1'b1;
                sel_idx_w   = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            en_q          <= '0;
            ptr_q         <= '0;
            ch_q          <= '0;
            to_cnt_q      <= '0;
            cyc_q         <= '0;
            high_cyc_q    <= '0;
            busy          <= 1'b0;
            sweep_done    <= 1'b0;
            res_valid     <= 1'b0;
            res_ch        <= '0;
            res_period_ns <= '0;
            res_high_ns   <= '0;
            res_timeout   <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            if (measuring) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
                if (cyc_q != '1) cyc_q <= cyc_q + CNT_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        en_q    <= ch_en;
                        busy    <= 1'b1;
                        ptr_q   <= '0;
                        state_q <= SEL;
                    end
                end
                SEL: begin
                    if (sel_found_w) begin
                        ch_q     <= sel_idx_w;
                        to_cnt_q <= '0;
                        state_q  <= ARM;
                    end else begin
                        sweep_done <= 1'b1;
                        if (mode_cont) begin
                            en_q  <= ch_en;
                            ptr_q <= '0;
                        end else begin
                            busy    <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                // A rise already present on the first ARM cycle is ignored
                ARM: begin
                    if (rise_sel && (to_cnt_q != '0)) begin
                        cyc_q   <= CNT_W'(1);
                        state_q <= HIGH;
                    end
                end
                HIGH: begin
                    if (fall_sel) begin
                        high_cyc_q <= cyc_q;
                        state_q    <= LOW;
                    end
                end
                LOW: begin
                    if (rise_sel) begin
                        res_valid     <= 1'b1;
                        res_ch        <= ch_q;
                        res_period_ns <= CNT_W'(cyc_q * NS_MUL);
                        res_high_ns   <= CNT_W'(high_cyc_q * NS_MUL);
                        res_timeout   <= 1'b0;
                        state_q       <= REPORT;
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        ptr_q     <= PTR_W'(ch_q) + PTR_W'(1);
                        state_q   <= SEL;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Timeout overrides any edge seen in the same cycle
            if (measuring && timeout_w) begin
                res_valid     <= 1'b1;
                res_ch        <= ch_q;
                res_period_ns <= '0;
                res_high_ns   <= '0;
                res_timeout   <= 1'b1;
                state_q       <= REPORT;
            end
        end
    end

endmodule

// File: tb/tb_signal_meas_sched.sv
// Directed bench for signal_meas_sched: expected-result table plus hand-written
// sequences for empty mask, backpressure, continuous mode and mid-measure reset.
`timescale 1ns/1ps
module tb_signal_meas_sched;
    logic        clk, rst_n, start, mode_cont, res_ready;
    logic [3:0]  ch_en, sig;
    logic        busy, sweep_done, res_valid, res_timeout;
    logic [2:0]  res_ch;
    logic [31:0] res_period_ns, res_high_ns;

    int checks = 0;
    int failures = 0;
    int sd_cnt = 0;
    int last_wait = 0;

    typedef struct {
        int ch;
        int per;
        int per_tol;
        int hi_lo;
        int hi_hi;
        bit to;
    } exp_t;
    exp_t tbl [5];

    signal_meas_sched #(
        .CH_NUM(4), .CNT_W(32), .CLK_PERIOD_NS(20), .TIMEOUT_CYC(1000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode_cont(mode_cont),
        .ch_en(ch_en), .signal(sig), .busy(busy), .sweep_done(sweep_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
        .res_period_ns(res_period_ns), .res_high_ns(res_high_ns),
        .res_timeout(res_timeout)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Input waveforms, offset 3 ns from clock edges
    initial begin
        sig = 4'b0000;
        #3;
        fork
            forever #130 sig[0] = ~sig[0];
            forever begin sig[1] = 1'b1; #400; sig[1] = 1'b0; #600; end
            forever begin sig[3] = 1'b1; #1000; sig[3] = 1'b0; #1000; end
        join_none
    end

    always @(negedge clk) if (sweep_done) sd_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input bit ok, input int act, input int exp_v);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp_v);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic get_res(input int max_cyc, output logic got, output int ch,
                           output int per, output int hi, output logic to);
        got = 1'b0; ch = 0; per = 0; hi = 0; to = 1'b0;
        last_wait = 0;
        for (int n = 0; n < max_cyc && !got; n++) begin
            @(negedge clk);
            last_wait = n + 1;
            if (res_valid) begin
                got = 1'b1;
                ch  = int'(res_ch);
                per = int'(res_period_ns);
                hi  = int'(res_high_ns);
                to  = res_timeout;
            end
        end
        if (got && res_ready) @(posedge clk);
    endtask

    task automatic check_res(input string tag, input int k, input int max_cyc);
        logic got, to;
        int ch, per, hi;
        get_res(max_cyc, got, ch, per, hi, to);
        chk({tag, ".valid"}, got, int'(got), 1);
        if (got) begin
            chk({tag, ".ch"}, ch == tbl[k].ch, ch, tbl[k].ch);
            chk({tag, ".period"}, (per >= tbl[k].per - tbl[k].per_tol) &&
                (per <= tbl[k].per + tbl[k].per_tol), per, tbl[k].per);
            chk({tag, ".high"}, (hi >= tbl[k].hi_lo) && (hi <= tbl[k].hi_hi), hi, tbl[k].hi_lo);
            chk({tag, ".timeout"}, to == tbl[k].to, int'(to), int'(tbl[k].to));
        end
    endtask

    task automatic wait_idle(input int max_cyc, output int nres, output logic idle);
        nres = 0;
        idle = 1'b0;
        for (int n = 0; n < max_cyc && !idle; n++) begin
            @(negedge clk);
            if (res_valid) nres++;
            if (!busy) idle = 1'b1;
        end
        #1;
    endtask

    initial begin
        int sd0, nres;
        logic idle;
        logic [2:0]  s_ch;
        logic [31:0] s_per, s_hi;
        logic        s_to, stable, quiet;

        tbl[0] = '{ch: 0, per: 260,  per_tol: 20, hi_lo: 120, hi_hi: 140,  to: 1'b0};
        tbl[1] = '{ch: 0, per: 260,  per_tol: 20, hi_lo: 120, hi_hi: 140,  to: 1'b0};
        tbl[2] = '{ch: 1, per: 1000, per_tol: 20, hi_lo: 380, hi_hi: 420,  to: 1'b0};
        tbl[3] = '{ch: 3, per: 2000, per_tol: 20, hi_lo: 980, hi_hi: 1020, to: 1'b0};
        tbl[4] = '{ch: 2, per: 0,    per_tol: 0,  hi_lo: 0,   hi_hi: 0,    to: 1'b1};

        rst_n = 1'b0; start = 1'b0; mode_cont = 1'b0; ch_en = 4'b0000; res_ready = 1'b1;
        #12;
        chk("reset.ctrl", {busy, sweep_done, res_valid, res_timeout} == 4'b0000,
            int'({busy, sweep_done, res_valid, res_timeout}), 0);
        chk("reset.data", (res_ch == 3'd0) && (res_period_ns == 32'd0) && (res_high_ns == 32'd0),
            int'(res_period_ns), 0);
        #2 rst_n = 1'b1;

        // Empty mask: sweep_done two cycles after start, no result
        ch_en = 4'b0000;
        sd0 = sd_cnt;
        pulse_start();
        chk("empty.busy_after_start", busy == 1'b1, int'(busy), 1);
        @(negedge clk);
        chk("empty.sweep_done", sweep_done == 1'b1, int'(sweep_done), 1);
        chk("empty.busy_drop", busy == 1'b0, int'(busy), 0);
        wait_idle(20, nres, idle);
        chk("empty.no_result", nres == 0, nres, 0);

        // Single channel
        ch_en = 4'b0001;
        sd0 = sd_cnt;
        pulse_start();
        check_res("t1", 0, 200);
        wait_idle(50, nres, idle);
        chk("t1.idle", idle, int'(idle), 1);
        chk("t1.sweep_done_cnt", sd_cnt - sd0 == 1, sd_cnt - sd0, 1);

        // Three channels in order; mid-sweep start must be ignored
        ch_en = 4'b1011;
        sd0 = sd_cnt;
        pulse_start();
        ch_en = 4'b0100;
        for (int k = 1; k <= 3; k++) begin
            check_res($sformatf("t2.r%0d", k), k, 400);
            if (k == 1) pulse_start();
        end
        wait_idle(50, nres, idle);
        chk("t2.idle", idle, int'(idle), 1);
        chk("t2.no_extra", nres == 0, nres, 0);
        chk("t2.sweep_done_cnt", sd_cnt - sd0 == 1, sd_cnt - sd0, 1);

        // Timeout on a stuck-low channel
        ch_en = 4'b0100;
        pulse_start();
        check_res("t3", 4, 1200);
        chk("t3.latency", (last_wait >= 995) && (last_wait <= 1010), last_wait, 1001);
        wait_idle(50, nres, idle);
        chk("t3.idle", idle, int'(idle), 1);

        // Backpressure: outputs frozen while res_ready is low
        ch_en = 4'b0011;
        res_ready = 1'b0;
        pulse_start();
        check_res("t4.first", 0, 200);
        s_ch = res_ch; s_per = res_period_ns; s_hi = res_high_ns; s_to = res_timeout;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            stable = res_valid && (res_ch == s_ch) && (res_period_ns == s_per) &&
                     (res_high_ns == s_hi) && (res_timeout == s_to);
            chk($sformatf("t4.stable%0d", n), stable, int'(res_period_ns), int'(s_per));
        end
        res_ready = 1'b1;
        @(posedge clk);
        check_res("t4.second", 2, 400);
        chk("t4.gap_after_handshake", last_wait >= 50, last_wait, 50);
        wait_idle(50, nres, idle);
        chk("t4.idle", idle, int'(idle), 1);

        // Continuous mode: repeated sweeps from a single start
        ch_en = 4'b0001;
        mode_cont = 1'b1;
        sd0 = sd_cnt;
        pulse_start();
        for (int k = 0; k < 3; k++) check_res($sformatf("t5.r%0d", k), 0, 200);
        chk("t5.sweeps", sd_cnt - sd0 >= 2, sd_cnt - sd0, 2);
        chk("t5.busy", busy == 1'b1, int'(busy), 1);
        @(negedge clk) mode_cont = 1'b0;
        wait_idle(300, nres, idle);
        chk("t5.stop", idle, int'(idle), 1);

        // Reset in the middle of a high phase
        ch_en = 4'b0001;
        pulse_start();
        @(posedge sig[0]);
        repeat (5) @(negedge clk);
        chk("t6.busy_before", busy == 1'b1, int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("t6.abort", (busy == 1'b0) && (res_valid == 1'b0), int'({busy, res_valid}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (res_valid || busy) quiet = 1'b0;
        end
        chk("t6.no_result", quiet, int'(quiet), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
